// File: rtl/video_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | video_pkg                                                            |
// | Shared types for the video generator: config fields, rectangle type. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package video_pkg;

    localparam int c_COORD_W = 10;

    typedef enum logic [1:0] {
        FLD_X0 = 2'd0,
        FLD_X1 = 2'd1,
        FLD_Y0 = 2'd2,
        FLD_Y1 = 2'd3
    } field_e;

    typedef struct packed {
        logic [c_COORD_W-1:0] x0;
        logic [c_COORD_W-1:0] x1;
        logic [c_COORD_W-1:0] y0;
        logic [c_COORD_W-1:0] y1;
    } rect_t;

    // An inverted rectangle (x0>x1 or y0>y1) cannot satisfy both bounds, so it never hits.
    function automatic logic rect_hit(input rect_t rc,
                                      input logic [c_COORD_W-1:0] px,
                                      input logic [c_COORD_W-1:0] py);
        return (rc.x0 <= px) && (px <= rc.x1) && (rc.y0 <= py) && (py <= rc.y1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/glyph_rom.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | glyph_rom                                                            |
// | Synchronous 8x8 font ROM, one pixel per read, 1-cycle latency.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module glyph_rom (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] code,
    input  logic [2:0] col,
    input  logic [2:0] row,
    output logic       pix
);

    // Row 0 in the top byte; column 0 is the MSB of each row.
    localparam logic [63:0] c_GLYPH_A = 64'h18_24_42_42_7E_42_42_00;
    localparam logic [63:0] c_GLYPH_B = 64'h7C_42_42_7C_42_42_7C_00;

    function automatic logic [7:0] font_row(input logic [7:0] c, input logic [2:0] rw);
        logic [7:0] bits;
        case (c)
            8'd65:   bits = c_GLYPH_A[63 - 8*int'(rw) -: 8];
            8'd66:   bits = c_GLYPH_B[63 - 8*int'(rw) -: 8];
            default: bits = (rw == 3'd0 || rw == 3'd7) ? 8'hFF : 8'h81;
        endcase
        return bits;
    endfunction

    logic [7:0] w_row;
    assign w_row = font_row(code, row);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pix <= 1'b0;
        else       pix <= w_row[3'd7 - col];
    end

endmodule
`default_nettype wire

// File: rtl/video_gen_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | video_gen_pipe                                                       |
// | 2-stage text + rectangle overlay generator with frame-synced config. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module video_gen_pipe
    import video_pkg::*;
#(
    parameter int         NRECT        = 2,
    parameter logic [7:0] CHAR_BASE    = 8'd65,
    parameter int         BLINK_FRAMES = 30
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [9:0]                 x,
    input  logic [9:0]                 y,
    input  logic                       hsync_in,
    input  logic                       vsync_in,
    input  logic                       blank_b_in,
    input  logic                       blink_en,
    input  logic                       cfg_we,
    input  logic [$clog2(NRECT)+1:0]   cfg_addr,
    input  logic [9:0]                 cfg_data,
    input  logic [NRECT-1:0]           rect_en,
    output logic [7:0]                 r,
    output logic [7:0]                 g,
    output logic [7:0]                 b,
    output logic                       hsync,
    output logic                       vsync,
    output logic                       blank_b,
    output logic [15:0]                frame_cnt
);

    localparam int c_AW = $clog2(NRECT) + 2;

    logic [c_AW-1:0]  w_idx;
    field_e           w_fld;
    logic             w_frame_start;
    logic [7:0]       w_code;
    logic [NRECT-1:0] w_hit_vec;

    logic             r_vs_prev;
    logic [NRECT-1:0] r_act_en;
    logic [15:0]      r_blink_cnt;
    logic             r_blink_phase;

    logic             r_pix1;
    logic             r_hit1;
    logic             r_y3_1;
    logic             r_sup1;
    logic             r_hs1;
    logic             r_vs1;
    logic             r_bl1;

    assign w_idx         = cfg_addr >> 2;
    assign w_fld         = field_e'(cfg_addr[1:0]);
    assign w_frame_start = r_vs_prev & ~vsync_in;
    assign w_code        = CHAR_BASE + {2'b00, y[8:3]};

    // Shadow takes writes at once; active copies shadow only at frame start,
    // so a same-cycle write is seen one frame later. Indices >= NRECT match no block.
    for (genvar gi = 0; gi < NRECT; gi++) begin : g_rect
        rect_t r_shadow;
        rect_t r_active;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_shadow <= '0;
                r_active <= '0;
            end else begin
                if (w_frame_start) r_active <= r_shadow;
                if (cfg_we && (w_idx == c_AW'(gi))) begin
                    case (w_fld)
                        FLD_X0: r_shadow.x0 <= cfg_data;
                        FLD_X1: r_shadow.x1 <= cfg_data;
                        FLD_Y0: r_shadow.y0 <= cfg_data;
                        FLD_Y1: r_shadow.y1 <= cfg_data;
                    endcase
                end
            end
        end

        assign w_hit_vec[gi] = r_act_en[gi] & rect_hit(r_active, x, y);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vs_prev     <= 1'b1;
            r_act_en      <= '0;
            frame_cnt     <= 16'd0;
            r_blink_cnt   <= 16'd0;
            r_blink_phase <= 1'b0;
        end else begin
            r_vs_prev <= vsync_in;
            if (w_frame_start) begin
                r_act_en  <= rect_en;
                frame_cnt <= frame_cnt + 16'd1;
                if (r_blink_cnt == 16'(BLINK_FRAMES - 1)) begin
                    r_blink_cnt   <= 16'd0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 16'd1;
                end
            end
        end
    end

    glyph_rom u_glyph_rom (
        .clk   (clk),
        .reset (reset),
        .code  (w_code),
        .col   (x[2:0]),
        .row   (y[2:0]),
        .pix   (r_pix1)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hit1 <= 1'b0;
            r_y3_1 <= 1'b0;
            r_sup1 <= 1'b0;
            r_hs1  <= 1'b1;
            r_vs1  <= 1'b1;
            r_bl1  <= 1'b0;
        end else begin
            r_hit1 <= |w_hit_vec;
            r_y3_1 <= y[3];
            r_sup1 <= blink_en & ~r_blink_phase;
            r_hs1  <= hsync_in;
            r_vs1  <= vsync_in;
            r_bl1  <= blank_b_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r       <= 8'h00;
            g       <= 8'h00;
            b       <= 8'h00;
            hsync   <= 1'b1;
            vsync   <= 1'b1;
            blank_b <= 1'b0;
        end else begin
            hsync   <= r_hs1;
            vsync   <= r_vs1;
            blank_b <= r_bl1;
            if (!r_bl1) begin
                r <= 8'h00;
                g <= 8'h00;
                b <= 8'h00;
            end else begin
                r <= (r_pix1 & ~r_sup1 & ~r_y3_1) ? 8'hFF : 8'h00;
                b <= (r_pix1 & ~r_sup1 &  r_y3_1) ? 8'hFF : 8'h00;
                g <= r_hit1 ? 8'hFF : 8'h00;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_video_gen_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_video_gen_pipe                                                    |
// | Directed self-checking bench for video_gen_pipe.                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_video_gen_pipe;

    localparam int NRECT = 3;
    // {r,g,b,hsync,vsync,blank_b,frame_cnt} while reset is held
    localparam logic [63:0] c_RST_VEC = {21'd0, 24'h000000, 3'b110, 16'h0000};

    logic             clk = 1'b0;
    logic             reset;
    logic [9:0]       x, y;
    logic             hsync_in, vsync_in, blank_b_in, blink_en, cfg_we;
    logic [3:0]       cfg_addr;
    logic [9:0]       cfg_data;
    logic [NRECT-1:0] rect_en;
    logic [7:0]       r, g, b;
    logic             hsync, vsync, blank_b;
    logic [15:0]      frame_cnt;

    int errors = 0;
    int checks = 0;

    video_gen_pipe #(.NRECT(NRECT), .CHAR_BASE(8'd65), .BLINK_FRAMES(2)) dut (
        .clk(clk), .reset(reset), .x(x), .y(y),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_b_in(blank_b_in),
        .blink_en(blink_en), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .rect_en(rect_en),
        .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync), .blank_b(blank_b),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] out_vec();
        return {21'd0, r, g, b, hsync, vsync, blank_b, frame_cnt};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one pixel and wait for it to reach the outputs (2 cycles).
    task automatic px(input logic [9:0] px_x, input logic [9:0] px_y);
        @(negedge clk);
        x = px_x;
        y = px_y;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic vs_edge();
        @(negedge clk) vsync_in = 1'b0;
        @(negedge clk) vsync_in = 1'b1;
    endtask

    task automatic cfg_wr(input logic [3:0] addr, input logic [9:0] data);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_data = data;
        @(negedge clk) cfg_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; x = '0; y = '0; hsync_in = 1'b1; vsync_in = 1'b1;
        blank_b_in = 1'b1; blink_en = 1'b0; cfg_we = 1'b0; cfg_addr = '0;
        cfg_data = '0; rect_en = '0;
        repeat (3) @(posedge clk);
        #1 chk("reset_init", out_vec(), c_RST_VEC);
        @(negedge clk) reset = 1'b0;

        // Text: row 0 is 'A' on r, row 1 is 'B' on b
        px(3, 0);  chk("txt_A_r0c3",  {48'd0, r, b}, {48'd0, 8'hFF, 8'h00});
        px(0, 0);  chk("txt_A_r0c0",  {48'd0, r, b}, {48'd0, 8'h00, 8'h00});
        px(1, 4);  chk("txt_A_r4c1",  {48'd0, r, b}, {48'd0, 8'hFF, 8'h00});
        px(1, 8);  chk("txt_B_r0c1",  {48'd0, r, b}, {48'd0, 8'h00, 8'hFF});
        px(0, 8);  chk("txt_B_r0c0",  {48'd0, r, b}, {48'd0, 8'h00, 8'h00});
        px(1, 12); chk("txt_B_r4c1",  {48'd0, r, b}, {48'd0, 8'h00, 8'hFF});
        px(3, 12); chk("txt_B_r4c3",  {48'd0, r, b}, {48'd0, 8'h00, 8'h00});

        // Sync/blank alignment against a lit text pixel
        px(3, 0);
        @(negedge clk); hsync_in = 1'b0; blank_b_in = 1'b0;
        @(posedge clk); #1;
        chk("align_lat1", {56'd0, r, hsync, blank_b}, {56'd0, 8'hFF, 1'b1, 1'b1});
        @(negedge clk); hsync_in = 1'b1; blank_b_in = 1'b1;
        @(posedge clk); #1;
        chk("align_lat2", {32'd0, r, g, b, hsync, blank_b}, {32'd0, 24'h000000, 1'b0, 1'b0});
        @(posedge clk); #1;
        chk("align_lat3", {56'd0, r, hsync, blank_b}, {56'd0, 8'hFF, 1'b1, 1'b1});

        // Asynchronous reset mid-line, held while inputs keep moving
        @(negedge clk); x = 10'd5;
        #2 reset = 1'b1;
        #1 chk("reset_async", out_vec(), c_RST_VEC);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            x = x + 10'd1;
            hsync_in = ~hsync_in;
            vsync_in = ~vsync_in;
            @(posedge clk); #1;
            chk("reset_hold", out_vec(), c_RST_VEC);
        end
        @(negedge clk); hsync_in = 1'b1; vsync_in = 1'b1; reset = 1'b0;

        // Rectangle 0 = (120,150,200,230), visible only after frame start
        cfg_wr(4'd0, 10'd120); cfg_wr(4'd1, 10'd150);
        cfg_wr(4'd2, 10'd200); cfg_wr(4'd3, 10'd230);
        rect_en = 3'b001;
        px(120, 200); chk("rect_pre_frame", {56'd0, g}, {56'd0, 8'h00});
        vs_edge();
        chk("frame_cnt_1", {48'd0, frame_cnt}, 64'd1);
        px(120, 200); chk("rect_corner_tl", {56'd0, g}, {56'd0, 8'hFF});
        px(150, 230); chk("rect_corner_br", {56'd0, g}, {56'd0, 8'hFF});
        px(151, 230); chk("rect_x_out",     {56'd0, g}, {56'd0, 8'h00});
        px(119, 200); chk("rect_x_lo_out",  {56'd0, g}, {56'd0, 8'h00});
        px(120, 231); chk("rect_y_out",     {56'd0, g}, {56'd0, 8'h00});

        // Write x1=140 in the frame-start cycle: old bounds for this frame
        @(negedge clk);
        vsync_in = 1'b0; cfg_we = 1'b1; cfg_addr = 4'd1; cfg_data = 10'd140;
        @(negedge clk); vsync_in = 1'b1; cfg_we = 1'b0;
        chk("frame_cnt_2", {48'd0, frame_cnt}, 64'd2);
        px(150, 230); chk("cfg_race_old", {56'd0, g}, {56'd0, 8'hFF});
        vs_edge();
        px(150, 230); chk("cfg_race_new_out", {56'd0, g}, {56'd0, 8'h00});
        px(140, 230); chk("cfg_race_new_in",  {56'd0, g}, {56'd0, 8'hFF});
        chk("frame_cnt_3", {48'd0, frame_cnt}, 64'd3);

        // Rectangle index NRECT is out of range and must change nothing
        cfg_wr(4'd12, 10'd0);  cfg_wr(4'd13, 10'd1023);
        cfg_wr(4'd14, 10'd0);  cfg_wr(4'd15, 10'd1023);
        rect_en = 3'b111;
        vs_edge();
        px(500, 500); chk("oor_no_hit",  {56'd0, g}, {56'd0, 8'h00});
        px(130, 210); chk("oor_r0_in",   {56'd0, g}, {56'd0, 8'hFF});
        px(141, 210); chk("oor_r0_x1",   {56'd0, g}, {56'd0, 8'h00});
        @(negedge clk) blank_b_in = 1'b0;
        px(130, 210); chk("blank_rect",  {40'd0, r, g, b}, 64'd0);
        px(3, 0);     chk("blank_text",  {40'd0, r, g, b}, 64'd0);
        @(negedge clk) blank_b_in = 1'b1;

        // Blink with 2 frames per phase; full-screen rect0 active from frame 1
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        blink_en = 1'b1;
        cfg_wr(4'd0, 10'd0); cfg_wr(4'd1, 10'd1023);
        cfg_wr(4'd2, 10'd0); cfg_wr(4'd3, 10'd1023);
        rect_en = 3'b001;
        px(3, 0); chk("blink_f0", {48'd0, r, g}, {48'd0, 8'h00, 8'h00});
        vs_edge();
        px(3, 0); chk("blink_f1", {48'd0, r, g}, {48'd0, 8'h00, 8'hFF});
        vs_edge();
        px(3, 0); chk("blink_f2", {48'd0, r, g}, {48'd0, 8'hFF, 8'hFF});
        vs_edge();
        px(3, 0); chk("blink_f3", {48'd0, r, g}, {48'd0, 8'hFF, 8'hFF});
        vs_edge();
        px(3, 0); chk("blink_f4", {48'd0, r, g}, {48'd0, 8'h00, 8'hFF});
        chk("frame_cnt_4", {48'd0, frame_cnt}, 64'd4);
        blink_en = 1'b0;
        px(3, 0); chk("blink_off", {48'd0, r, g}, {48'd0, 8'hFF, 8'hFF});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
